register_access_stage: RTL and testbench

//  Register-access pipeline stage between decode and address generation.

---
 rtl/register_access_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_register_access_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_access_stage.sv
// Register-access stage: holds the GPR/segment/MMX register file, resolves operand
// register numbers, computes the stack/string address and registers everything toward AGEN.
module register_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] write_cs,
    input  logic        write_cs_enable,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_size,
    input  logic        d_set_d_flag,
    input  logic        d_clear_d_flag,
    input  logic [2:0]  d_op0,
    input  logic [2:0]  d_op1,
    input  logic [2:0]  d_op0_reg,
    input  logic [2:0]  d_op1_reg,
    input  logic [7:0]  d_modrm,
    input  logic [7:0]  d_sib,
    input  logic [47:0] d_imm,
    input  logic [31:0] d_disp,
    input  logic [3:0]  d_alu_op,
    input  logic [2:0]  d_flag_0,
    input  logic [2:0]  d_flag_1,
    input  logic [1:0]  d_stack_op,
    input  logic [2:0]  d_seg_override,
    input  logic        d_seg_override_valid,
    input  logic        d_movs,
    input  logic [31:0] d_pc,
    input  logic        d_branch_taken,
    input  logic [15:0] d_opcode,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [2:0]  r_size,
    output logic        r_set_d_flag,
    output logic        r_clear_d_flag,
    output logic [2:0]  r_op0,
    output logic [2:0]  r_op1,
    output logic [2:0]  r_op0_reg,
    output logic [2:0]  r_op1_reg,
    output logic [7:0]  r_modrm,
    output logic [7:0]  r_sib,
    output logic [47:0] r_imm,
    output logic [31:0] r_disp,
    output logic [3:0]  r_alu_op,
    output logic [2:0]  r_flag_0,
    output logic [2:0]  r_flag_1,
    output logic [1:0]  r_stack_op,
    output logic [2:0]  r_seg_override,
    output logic        r_seg_override_valid,
    output logic [31:0] r_pc,
    output logic        r_branch_taken,
    output logic [15:0] r_opcode,
    output logic [31:0] r_stack_address,
    output logic [31:0] r_eax,
    output logic [31:0] r_ecx,
    output logic [31:0] r_edx,
    output logic [31:0] r_ebx,
    output logic [31:0] r_esp,
    output logic [31:0] r_ebp,
    output logic [31:0] r_esi,
    output logic [31:0] r_edi,
    output logic [15:0] r_cs,
    output logic [15:0] r_ds,
    output logic [15:0] r_es,
    output logic [15:0] r_fs,
    output logic [15:0] r_gs,
    output logic [15:0] r_ss,
    output logic [63:0] r_mm0,
    output logic [63:0] r_mm1,
    output logic [63:0] r_mm2,
    output logic [63:0] r_mm3,
    output logic [63:0] r_mm4,
    output logic [63:0] r_mm5,
    output logic [63:0] r_mm6,
    output logic [63:0] r_mm7,
    input  logic [2:0]  wb_reg_number,
    input  logic        wb_reg_en,
    input  logic        wb_stack,
    input  logic [2:0]  wb_reg_size,
    input  logic [31:0] wb_reg_data,
    input  logic [2:0]  wb_seg_number,
    input  logic        wb_seg_en,
    input  logic [15:0] wb_seg_data,
    input  logic [2:0]  wb_mmx_number,
    input  logic        wb_mmx_en,
    input  logic [63:0] wb_mmx_data,
    input  logic        flag_df
);

    typedef struct packed {
        logic [2:0]  size;
        logic        set_d_flag;
        logic        clear_d_flag;
        logic [2:0]  op0;
        logic [2:0]  op1;
        logic [2:0]  op0_reg;
        logic [2:0]  op1_reg;
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic [47:0] imm;
        logic [31:0] disp;
        logic [3:0]  alu_op;
        logic [2:0]  flag_0;
        logic [2:0]  flag_1;
        logic [1:0]  stack_op;
        logic [2:0]  seg_override;
        logic        seg_override_valid;
        logic [31:0] pc;
        logic        branch_taken;
        logic [15:0] opcode;
        logic [31:0] stack_address;
    } payload_t;

    localparam int SEG_CS = 1;
    localparam int GPR_ESP = 4;
    localparam int GPR_EDI = 7;

    // Direction flag is consumed further down the pipe, not here.
    logic unused_flag_df;
    assign unused_flag_df = flag_df;

    logic [31:0] gpr_q [8];
    logic [31:0] gpr_d [8];
    logic [15:0] seg_q [6];
    logic [15:0] seg_d [6];
    logic [63:0] mmx_q [8];
    logic [63:0] mmx_d [8];

    logic [31:0] gpr_snap_q [8];
    logic [15:0] seg_snap_q [6];
    logic [63:0] mmx_snap_q [8];

    payload_t payload_q, payload_d;
    logic     r_valid_q, r_valid_d;
    logic     capture;
    logic [31:0] stack_addr;

    function automatic logic [2:0] sel_reg(input logic [2:0] mode, input logic [7:0] modrm,
                                           input logic [2:0] reg_in);
        case (mode)
            3'd3:    return modrm[5:3];
            3'd4:    return modrm[2:0];
            default: return reg_in;
        endcase
    endfunction

    assign d_ready = r_ready | ~r_valid_q;
    assign capture = d_valid & d_ready;

    // Write-first view of the register file: this cycle's writebacks are visible to the snapshot.
    always_comb begin
        gpr_d = gpr_q;
        if (wb_reg_en) begin
            if (wb_stack) begin
                gpr_d[GPR_ESP] = wb_reg_data;
            end else begin
                case (wb_reg_size)
                    3'd0: begin
                        if (!wb_reg_number[2])
                            gpr_d[wb_reg_number][7:0] = wb_reg_data[7:0];
                        else
                            gpr_d[{1'b0, wb_reg_number[1:0]}][15:8] = wb_reg_data[7:0];
                    end
                    3'd1:    gpr_d[wb_reg_number][15:0] = wb_reg_data[15:0];
                    default: gpr_d[wb_reg_number] = wb_reg_data;
                endcase
            end
        end
    end

    always_comb begin
        seg_d = seg_q;
        for (int i = 0; i < 6; i++) begin
            if (wb_seg_en && wb_seg_number == i[2:0])
                seg_d[i] = wb_seg_data;
        end
        if (write_cs_enable)
            seg_d[SEG_CS] = write_cs;
    end

    always_comb begin
        mmx_d = mmx_q;
        if (wb_mmx_en)
            mmx_d[wb_mmx_number] = wb_mmx_data;
    end

    always_comb begin
        if (d_stack_op == 2'd1)
            stack_addr = gpr_d[GPR_ESP] - ((d_size == 3'd1) ? 32'd2 : 32'd4);
        else if (d_stack_op == 2'd2)
            stack_addr = gpr_d[GPR_ESP];
        else if (d_movs)
            stack_addr = gpr_d[GPR_EDI];
        else
            stack_addr = gpr_d[GPR_ESP];
    end

    always_comb begin
        payload_d.size               = d_size;
        payload_d.set_d_flag         = d_set_d_flag;
        payload_d.clear_d_flag       = d_clear_d_flag;
        payload_d.op0                = d_op0;
        payload_d.op1                = d_op1;
        payload_d.op0_reg            = sel_reg(d_op0, d_modrm, d_op0_reg);
        payload_d.op1_reg            = sel_reg(d_op1, d_modrm, d_op1_reg);
        payload_d.modrm              = d_modrm;
        payload_d.sib                = d_sib;
        payload_d.imm                = d_imm;
        payload_d.disp               = d_disp;
        payload_d.alu_op             = d_alu_op;
        payload_d.flag_0             = d_flag_0;
        payload_d.flag_1             = d_flag_1;
        payload_d.stack_op           = d_stack_op;
        payload_d.seg_override       = d_seg_override;
        payload_d.seg_override_valid = d_seg_override_valid;
        payload_d.pc                 = d_pc;
        payload_d.branch_taken       = d_branch_taken;
        payload_d.opcode             = d_opcode;
        payload_d.stack_address      = stack_addr;
    end

    // Flush has priority over a same-cycle capture.
    always_comb begin
        r_valid_d = r_valid_q;
        if (flush)
            r_valid_d = 1'b0;
        else if (capture)
            r_valid_d = 1'b1;
        else if (r_ready)
            r_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            payload_q <= '0;
            for (int i = 0; i < 8; i++) begin
                gpr_q[i]      <= '0;
                mmx_q[i]      <= '0;
                gpr_snap_q[i] <= '0;
                mmx_snap_q[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                seg_q[i]      <= '0;
                seg_snap_q[i] <= '0;
            end
        end else begin
            r_valid_q <= r_valid_d;
            gpr_q     <= gpr_d;
            seg_q     <= seg_d;
            mmx_q     <= mmx_d;
            if (capture) begin
                payload_q  <= payload_d;
                gpr_snap_q <= gpr_d;
                seg_snap_q <= seg_d;
                mmx_snap_q <= mmx_d;
            end
        end
    end

    assign r_valid              = r_valid_q;
    assign r_size               = payload_q.size;
    assign r_set_d_flag         = payload_q.set_d_flag;
    assign r_clear_d_flag       = payload_q.clear_d_flag;
    assign r_op0                = payload_q.op0;
    assign r_op1                = payload_q.op1;
    assign r_op0_reg            = payload_q.op0_reg;
    assign r_op1_reg            = payload_q.op1_reg;
    assign r_modrm              = payload_q.modrm;
    assign r_sib                = payload_q.sib;
    assign r_imm                = payload_q.imm;
    assign r_disp               = payload_q.disp;
    assign r_alu_op             = payload_q.alu_op;
    assign r_flag_0             = payload_q.flag_0;
    assign r_flag_1             = payload_q.flag_1;
    assign r_stack_op           = payload_q.stack_op;
    assign r_seg_override       = payload_q.seg_override;
    assign r_seg_override_valid = payload_q.seg_override_valid;
    assign r_pc                 = payload_q.pc;
    assign r_branch_taken       = payload_q.branch_taken;
    assign r_opcode             = payload_q.opcode;
    assign r_stack_address      = payload_q.stack_address;

    assign r_eax = gpr_snap_q[0];
    assign r_ecx = gpr_snap_q[1];
    assign r_edx = gpr_snap_q[2];
    assign r_ebx = gpr_snap_q[3];
    assign r_esp = gpr_snap_q[4];
    assign r_ebp = gpr_snap_q[5];
    assign r_esi = gpr_snap_q[6];
    assign r_edi = gpr_snap_q[7];

    assign r_es = seg_snap_q[0];
    assign r_cs = seg_snap_q[1];
    assign r_ss = seg_snap_q[2];
    assign r_ds = seg_snap_q[3];
    assign r_fs = seg_snap_q[4];
    assign r_gs = seg_snap_q[5];

    assign r_mm0 = mmx_snap_q[0];
    assign r_mm1 = mmx_snap_q[1];
    assign r_mm2 = mmx_snap_q[2];
    assign r_mm3 = mmx_snap_q[3];
    assign r_mm4 = mmx_snap_q[4];
    assign r_mm5 = mmx_snap_q[5];
    assign r_mm6 = mmx_snap_q[6];
    assign r_mm7 = mmx_snap_q[7];

endmodule

// File: tb/tb_register_access_stage.sv
// Scoreboard bench for register_access_stage: a driver pushes hand-computed expectations,
// a monitor pops and compares each output the DUT hands to AGEN.
module tb_register_access_stage;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [15:0] write_cs;
    logic        write_cs_enable;
    logic        d_valid, d_ready;
    logic [2:0]  d_size;
    logic        d_set_d_flag, d_clear_d_flag;
    logic [2:0]  d_op0, d_op1, d_op0_reg, d_op1_reg;
    logic [7:0]  d_modrm, d_sib;
    logic [47:0] d_imm;
    logic [31:0] d_disp;
    logic [3:0]  d_alu_op;
    logic [2:0]  d_flag_0, d_flag_1;
    logic [1:0]  d_stack_op;
    logic [2:0]  d_seg_override;
    logic        d_seg_override_valid, d_movs;
    logic [31:0] d_pc;
    logic        d_branch_taken;
    logic [15:0] d_opcode;
    logic        r_valid, r_ready;
    logic [2:0]  r_size;
    logic        r_set_d_flag, r_clear_d_flag;
    logic [2:0]  r_op0, r_op1, r_op0_reg, r_op1_reg;
    logic [7:0]  r_modrm, r_sib;
    logic [47:0] r_imm;
    logic [31:0] r_disp;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_flag_0, r_flag_1;
    logic [1:0]  r_stack_op;
    logic [2:0]  r_seg_override;
    logic        r_seg_override_valid;
    logic [31:0] r_pc;
    logic        r_branch_taken;
    logic [15:0] r_opcode;
    logic [31:0] r_stack_address;
    logic [31:0] r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi;
    logic [15:0] r_cs, r_ds, r_es, r_fs, r_gs, r_ss;
    logic [63:0] r_mm0, r_mm1, r_mm2, r_mm3, r_mm4, r_mm5, r_mm6, r_mm7;
    logic [2:0]  wb_reg_number, wb_reg_size;
    logic        wb_reg_en, wb_stack;
    logic [31:0] wb_reg_data;
    logic [2:0]  wb_seg_number;
    logic        wb_seg_en;
    logic [15:0] wb_seg_data;
    logic [2:0]  wb_mmx_number;
    logic        wb_mmx_en;
    logic [63:0] wb_mmx_data;
    logic        flag_df;

    register_access_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .write_cs(write_cs), .write_cs_enable(write_cs_enable),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_size(d_size), .d_set_d_flag(d_set_d_flag), .d_clear_d_flag(d_clear_d_flag),
        .d_op0(d_op0), .d_op1(d_op1), .d_op0_reg(d_op0_reg), .d_op1_reg(d_op1_reg),
        .d_modrm(d_modrm), .d_sib(d_sib), .d_imm(d_imm), .d_disp(d_disp),
        .d_alu_op(d_alu_op), .d_flag_0(d_flag_0), .d_flag_1(d_flag_1),
        .d_stack_op(d_stack_op), .d_seg_override(d_seg_override),
        .d_seg_override_valid(d_seg_override_valid), .d_movs(d_movs), .d_pc(d_pc),
        .d_branch_taken(d_branch_taken), .d_opcode(d_opcode),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_size(r_size), .r_set_d_flag(r_set_d_flag), .r_clear_d_flag(r_clear_d_flag),
        .r_op0(r_op0), .r_op1(r_op1), .r_op0_reg(r_op0_reg), .r_op1_reg(r_op1_reg),
        .r_modrm(r_modrm), .r_sib(r_sib), .r_imm(r_imm), .r_disp(r_disp),
        .r_alu_op(r_alu_op), .r_flag_0(r_flag_0), .r_flag_1(r_flag_1),
        .r_stack_op(r_stack_op), .r_seg_override(r_seg_override),
        .r_seg_override_valid(r_seg_override_valid), .r_pc(r_pc),
        .r_branch_taken(r_branch_taken), .r_opcode(r_opcode),
        .r_stack_address(r_stack_address),
        .r_eax(r_eax), .r_ecx(r_ecx), .r_edx(r_edx), .r_ebx(r_ebx),
        .r_esp(r_esp), .r_ebp(r_ebp), .r_esi(r_esi), .r_edi(r_edi),
        .r_cs(r_cs), .r_ds(r_ds), .r_es(r_es), .r_fs(r_fs), .r_gs(r_gs), .r_ss(r_ss),
        .r_mm0(r_mm0), .r_mm1(r_mm1), .r_mm2(r_mm2), .r_mm3(r_mm3),
        .r_mm4(r_mm4), .r_mm5(r_mm5), .r_mm6(r_mm6), .r_mm7(r_mm7),
        .wb_reg_number(wb_reg_number), .wb_reg_en(wb_reg_en), .wb_stack(wb_stack),
        .wb_reg_size(wb_reg_size), .wb_reg_data(wb_reg_data),
        .wb_seg_number(wb_seg_number), .wb_seg_en(wb_seg_en), .wb_seg_data(wb_seg_data),
        .wb_mmx_number(wb_mmx_number), .wb_mmx_en(wb_mmx_en), .wb_mmx_data(wb_mmx_data),
        .flag_df(flag_df)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op0r;
        logic [2:0]  op1r;
        logic [31:0] sa;
        logic [31:0] eax;
        logic [31:0] esp;
        logic [15:0] cs;
        logic [63:0] mm3;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] pc_n = 32'h100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic clear_wb();
        wb_reg_en = 0; wb_stack = 0; wb_reg_number = 0; wb_reg_size = 0; wb_reg_data = 0;
        wb_seg_en = 0; wb_seg_number = 0; wb_seg_data = 0;
        wb_mmx_en = 0; wb_mmx_number = 0; wb_mmx_data = 0;
        write_cs_enable = 0; write_cs = 0;
    endtask

    task automatic op(input logic [2:0] m0, input logic [2:0] m1, input logic [2:0] r0,
                      input logic [2:0] r1, input logic [7:0] modrm, input logic [1:0] sop,
                      input logic [2:0] size, input logic movs);
        d_op0 = m0; d_op1 = m1; d_op0_reg = r0; d_op1_reg = r1;
        d_modrm = modrm; d_stack_op = sop; d_size = size; d_movs = movs;
    endtask

    // Issue one instruction (with any writeback already set) and record its expected result.
    task automatic go(input logic [2:0] e0, input logic [2:0] e1, input logic [31:0] sa,
                      input logic [31:0] eax, input logic [31:0] esp, input logic [15:0] cs,
                      input logic [63:0] mm3);
        exp_t e;
        pc_n = pc_n + 32'h10;
        d_pc = pc_n;
        e.op0r = e0; e.op1r = e1; e.sa = sa; e.eax = eax; e.esp = esp;
        e.cs = cs; e.mm3 = mm3; e.pc = pc_n;
        exp_q.push_back(e);
        d_valid = 1;
        @(posedge clk); #1;
        d_valid = 0;
        clear_wb();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_pc", r_pc, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", r_pc, e.pc);
                    chk("op0_reg", r_op0_reg, e.op0r);
                    chk("op1_reg", r_op1_reg, e.op1r);
                    chk("stack_address", r_stack_address, e.sa);
                    chk("eax", r_eax, e.eax);
                    chk("esp", r_esp, e.esp);
                    chk("cs", r_cs, e.cs);
                    chk("mm3", r_mm3, e.mm3);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1; flush = 0; d_valid = 0; r_ready = 1; flag_df = 0;
        d_set_d_flag = 0; d_clear_d_flag = 0; d_sib = 8'h00; d_imm = 48'h0;
        d_disp = 32'h0; d_alu_op = 0; d_flag_0 = 0; d_flag_1 = 0; d_seg_override = 0;
        d_seg_override_valid = 0; d_branch_taken = 0; d_opcode = 16'h0; d_pc = 0;
        op(0, 0, 0, 0, 8'h00, 0, 0, 0);
        clear_wb();
        @(posedge clk); #1;
        reset = 0;
        chk("reset_r_valid", r_valid, 0);
        chk("reset_d_ready", d_ready, 1);
        chk("reset_r_esp", r_esp, 0);
        chk("reset_r_stack_address", r_stack_address, 0);
        chk("reset_r_mm3", r_mm3, 0);

        op(1, 1, 2, 3, 8'h00, 0, 2, 0); go(2, 3, 0, 0, 0, 0, 0);
        op(4, 4, 1, 1, 8'hFF, 0, 2, 0); go(7, 7, 0, 0, 0, 0, 0);
        op(3, 3, 6, 6, 8'h18, 0, 2, 0); go(3, 3, 0, 0, 0, 0, 0);
        op(1, 2, 5, 6, 8'h00, 0, 2, 0);
        wb_reg_en = 1; wb_reg_number = 4; wb_reg_size = 2; wb_reg_data = 32'h1000;
        go(5, 6, 32'h1000, 0, 32'h1000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 1, 2, 0); go(0, 0, 32'h0FFC, 0, 32'h1000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 1, 1, 0); go(0, 0, 32'h0FFE, 0, 32'h1000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 2, 2, 0); go(0, 0, 32'h1000, 0, 32'h1000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 0, 2, 0);
        wb_reg_en = 1; wb_reg_number = 0; wb_reg_size = 2; wb_reg_data = 32'h11223344;
        go(0, 0, 32'h1000, 32'h11223344, 32'h1000, 0, 0);
        wb_reg_en = 1; wb_reg_number = 4; wb_reg_size = 0; wb_reg_data = 32'hFFFFFFAB;
        go(0, 0, 32'h1000, 32'h1122AB44, 32'h1000, 0, 0);
        wb_reg_en = 1; wb_reg_number = 0; wb_reg_size = 0; wb_reg_data = 32'hEEEEEE55;
        go(0, 0, 32'h1000, 32'h1122AB55, 32'h1000, 0, 0);
        wb_reg_en = 1; wb_reg_number = 0; wb_reg_size = 1; wb_reg_data = 32'hFFFF9999;
        go(0, 0, 32'h1000, 32'h11229999, 32'h1000, 0, 0);
        wb_reg_en = 1; wb_stack = 1; wb_reg_number = 0; wb_reg_size = 0; wb_reg_data = 32'h2000;
        go(0, 0, 32'h2000, 32'h11229999, 32'h2000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 0, 2, 1);
        wb_reg_en = 1; wb_reg_number = 7; wb_reg_size = 2; wb_reg_data = 32'h3000;
        go(0, 0, 32'h3000, 32'h11229999, 32'h2000, 0, 0);
        op(1, 1, 0, 0, 8'h00, 0, 2, 0);
        write_cs_enable = 1; write_cs = 16'h1234;
        wb_seg_en = 1; wb_seg_number = 1; wb_seg_data = 16'h5678;
        go(0, 0, 32'h2000, 32'h11229999, 32'h2000, 16'h1234, 0);
        wb_seg_en = 1; wb_seg_number = 1; wb_seg_data = 16'h5678;
        go(0, 0, 32'h2000, 32'h11229999, 32'h2000, 16'h5678, 0);
        wb_mmx_en = 1; wb_mmx_number = 3; wb_mmx_data = 64'h0123456789ABCDEF;
        go(0, 0, 32'h2000, 32'h11229999, 32'h2000, 16'h5678, 64'h0123456789ABCDEF);

        // Stall: downstream not ready; the held instruction must not change.
        @(posedge clk); #1;
        r_ready = 0;
        op(1, 1, 4, 1, 8'h00, 0, 2, 0);
        d_pc = 32'hA0; d_valid = 1;
        @(posedge clk); #1;
        op(1, 1, 7, 7, 8'h00, 0, 2, 0);
        d_pc = 32'hB0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_d_ready", d_ready, 0);
        chk("stall_r_valid", r_valid, 1);
        chk("stall_r_pc", r_pc, 32'hA0);
        chk("stall_r_op0_reg", r_op0_reg, 4);
        d_valid = 0; flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_r_valid", r_valid, 0);
        r_ready = 1; d_valid = 1; flush = 1;
        @(posedge clk); #1;
        d_valid = 0; flush = 0;
        chk("flush_beats_capture_r_valid", r_valid, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
